tt_io_sequencer: RTL and testbench

//  Parametrised stimulus/capture engine for Tiny Tapeout user-module benches and on-board self-test.

---
 rtl/tt_io_seq_if.sv | 32 +++
 rtl/tt_io_sequencer.sv | 135 +++++++++++++
 tb/tb_tt_io_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tt_io_seq_if.sv
// Host-side bundle for the Tiny Tapeout I/O sequencer: run control, stimulus table
// writes, capture buffer reads and run status.
interface tt_io_seq_if #(
    parameter int IO_W  = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic [AW:0]       stim_len;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [2*IO_W-1:0] wr_data;
    logic [AW-1:0]     cap_rd_addr;
    logic [2*IO_W-1:0] cap_rd_data;
    logic [AW:0]       cap_count;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start, stop, mode, stim_len, wr_en, wr_addr, wr_data, cap_rd_addr,
        input  cap_rd_data, cap_count, busy, done, overflow
    );

    modport slave (
        input  start, stop, mode, stim_len, wr_en, wr_addr, wr_data, cap_rd_addr,
        output cap_rd_data, cap_count, busy, done, overflow
    );
endinterface

// File: rtl/tt_io_sequencer.sv
// Stimulus/capture engine for tt_um_* benches: plays a vector table onto ui_in/uio_in
// one word per clock and records uo_out plus the enabled uio_out bits.
module tt_io_sequencer #(
    parameter int IO_W  = 8,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    tt_io_seq_if.slave      bus,
    input  logic [IO_W-1:0] trig_mask,
    input  logic [IO_W-1:0] trig_value,
    input  logic [IO_W-1:0] dut_uo,
    input  logic [IO_W-1:0] dut_uio,
    input  logic [IO_W-1:0] dut_uio_oe,
    output logic [IO_W-1:0] ui_drive,
    output logic [IO_W-1:0] uio_drive
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t            state;
    logic [AW-1:0]     ptr;
    logic [AW-1:0]     cap_idx;
    logic [AW:0]       len_q;
    logic              loop_q;
    logic [AW:0]       cap_count;
    logic              busy;
    logic              done;
    logic              overflow;

    logic [2*IO_W-1:0] stim_mem [DEPTH];
    logic [2*IO_W-1:0] cap_mem  [DEPTH];

    logic [AW:0]       eff_len;
    logic [AW:0]       len_m1;
    logic              idle_like;
    logic              trig_hit;
    logic              stim_we;
    logic              cap_we;

    always_comb begin
        eff_len   = (bus.stim_len == '0 || bus.stim_len > DEPTH_C) ? DEPTH_C : bus.stim_len;
        len_m1    = len_q - (AW+1)'(1);
        idle_like = (state == IDLE) || (state == DONE);
        trig_hit  = ((dut_uo ^ trig_value) & trig_mask) == '0;
        stim_we   = bus.wr_en && idle_like;
        cap_we    = (state == RUN) && !bus.stop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cap_idx   <= '0;
            len_q     <= DEPTH_C;
            loop_q    <= 1'b0;
            cap_count <= '0;
            ui_drive  <= '0;
            uio_drive <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start && !bus.stop) begin
                        state     <= (bus.mode == 2'd2) ? ARM : RUN;
                        ptr       <= '0;
                        cap_idx   <= '0;
                        cap_count <= '0;
                        overflow  <= 1'b0;
                        len_q     <= eff_len;
                        loop_q    <= (bus.mode == 2'd1);
                        busy      <= 1'b1;
                        if (bus.mode == 2'd2) begin
                            ui_drive  <= '0;
                            uio_drive <= '0;
                        end
                    end
                end
                ARM: begin
                    if (bus.stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (trig_hit) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        {uio_drive, ui_drive} <= stim_mem[ptr];
                        cap_idx <= cap_idx + AW'(1);
                        if (cap_count != DEPTH_C) cap_count <= cap_count + (AW+1)'(1);
                        // Loop mode only: writing the last slot means the next capture overwrites entry 0.
                        if (loop_q && cap_idx == LAST_IDX) overflow <= 1'b1;
                        if (ptr == len_m1[AW-1:0]) begin
                            if (loop_q) begin
                                ptr <= '0;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the tables are plain RAM with no reset so they map onto memory macros; contents survive rst.
    always_ff @(posedge clk) begin
        if (stim_we) stim_mem[bus.wr_addr] <= bus.wr_data;
        if (cap_we)  cap_mem[cap_idx]      <= {dut_uio & dut_uio_oe, dut_uo};
    end

    assign bus.cap_rd_data = cap_mem[bus.cap_rd_addr];
    assign bus.cap_count   = cap_count;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.overflow    = overflow;
endmodule

// File: tb/tb_tt_io_sequencer.sv
// Directed bench for tt_io_sequencer: single, loopback capture, trigger, loop/overflow,
// start+stop priority, dropped writes while running, and mid-run reset.
module tb_tt_io_sequencer;
    localparam int IO_W  = 8;
    localparam int DEPTH = 16;

    logic            clk;
    logic            rst;
    logic [IO_W-1:0] trig_mask;
    logic [IO_W-1:0] trig_value;
    logic [IO_W-1:0] dut_uio;
    logic [IO_W-1:0] dut_uio_oe;
    logic [IO_W-1:0] ui_drive;
    logic [IO_W-1:0] uio_drive;
    logic            loop_en;
    logic [IO_W-1:0] uo_force;
    wire  [IO_W-1:0] dut_uo;

    int total;
    int bad;

    tt_io_seq_if #(.IO_W(IO_W), .DEPTH(DEPTH)) bus ();

    tt_io_sequencer #(.IO_W(IO_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .dut_uo     (dut_uo),
        .dut_uio    (dut_uio),
        .dut_uio_oe (dut_uio_oe),
        .ui_drive   (ui_drive),
        .uio_drive  (uio_drive)
    );

    // Combinational stand-in for the user module: either echoes ui_in or outputs a forced value.
    assign dut_uo = loop_en ? ui_drive : uo_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_stim(input logic [3:0] addr, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (ui_drive !== 8'h00) begin bad++; $display("FAIL reset_ui: got %h want 00", ui_drive); end
        total++; if (uio_drive !== 8'h00) begin bad++; $display("FAIL reset_uio: got %h want 00", uio_drive); end
        total++; if (bus.cap_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.cap_count); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    endtask

    // Single-shot run of stim[0..3] with loopback; table must already hold 01,02,04,08.
    task automatic test_single(input string tag);
        logic [7:0] exp_ui [4];
        exp_ui = '{8'h01, 8'h02, 8'h04, 8'h08};
        loop_en = 1'b1; dut_uio = 8'hFF; dut_uio_oe = 8'h0F;
        bus.mode = 2'd0; bus.stim_len = 5'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b want 1", tag, bus.busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (ui_drive !== exp_ui[i]) begin bad++; $display("FAIL %s_ui%0d: got %h want %h", tag, i, ui_drive, exp_ui[i]); end
            total++; if (uio_drive !== 8'h00) begin bad++; $display("FAIL %s_uio%0d: got %h want 00", tag, i, uio_drive); end
            total++; if (bus.done !== (i == 3)) begin bad++; $display("FAIL %s_done%0d: got %b want %b", tag, i, bus.done, (i == 3)); end
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_idle: got busy %b want 0", tag, bus.busy); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_pulse: got done %b want 0", tag, bus.done); end
        total++; if (bus.cap_count !== 5'd4) begin bad++; $display("FAIL %s_count: got %0d want 4", tag, bus.cap_count); end
        total++; if (ui_drive !== 8'h08) begin bad++; $display("FAIL %s_hold: got %h want 08", tag, ui_drive); end
    endtask

    task automatic test_loopback_capture();
        logic [15:0] exp_cap [4];
        exp_cap = '{16'h0F00, 16'h0F01, 16'h0F02, 16'h0F04};
        for (int i = 0; i < 4; i++) begin
            bus.cap_rd_addr = 4'(i);
            #1;
            total++; if (bus.cap_rd_data !== exp_cap[i]) begin bad++; $display("FAIL cap%0d: got %h want %h", i, bus.cap_rd_data, exp_cap[i]); end
        end
    endtask

    task automatic test_trigger();
        int busy_cycles;
        busy_cycles = 0;
        loop_en = 1'b0; uo_force = 8'h5A;
        trig_mask = 8'hF0; trig_value = 8'hA0;
        bus.mode = 2'd2; bus.stim_len = 5'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (bus.busy) busy_cycles++;
        total++; if (ui_drive !== 8'h00) begin bad++; $display("FAIL trig_arm_zero: got %h want 00", ui_drive); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.busy) busy_cycles++;
            total++; if (ui_drive !== 8'h00) begin bad++; $display("FAIL trig_wait%0d: got %h want 00", i, ui_drive); end
        end
        uo_force = 8'hA3;
        tick();
        if (bus.busy) busy_cycles++;
        total++; if (ui_drive !== 8'h00) begin bad++; $display("FAIL trig_seen: got %h want 00", ui_drive); end
        tick();
        if (bus.busy) busy_cycles++;
        total++; if (ui_drive !== 8'h01) begin bad++; $display("FAIL trig_first: got %h want 01", ui_drive); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL trig_done: got %b want 1", bus.done); end
        total++; if (busy_cycles != 7) begin bad++; $display("FAIL trig_busy_len: got %0d want 7", busy_cycles); end
        total++; if (bus.cap_count !== 5'd1) begin bad++; $display("FAIL trig_count: got %0d want 1", bus.cap_count); end
        bus.cap_rd_addr = 4'd0;
        #1;
        total++; if (bus.cap_rd_data !== 16'h0FA3) begin bad++; $display("FAIL trig_cap0: got %h want 0FA3", bus.cap_rd_data); end
    endtask

    task automatic test_loop();
        logic [7:0] pat [3];
        pat = '{8'h01, 8'h02, 8'h04};
        loop_en = 1'b0; uo_force = 8'h33;
        bus.mode = 2'd1; bus.stim_len = 5'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++; if (ui_drive !== pat[(k-1) % 3]) begin bad++; $display("FAIL loop_ui%0d: got %h want %h", k, ui_drive, pat[(k-1) % 3]); end
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL loop_nodone%0d: got %b want 0", k, bus.done); end
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL loop_done: got %b want 1", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL loop_busy: got %b want 0", bus.busy); end
        total++; if (ui_drive !== 8'h02) begin bad++; $display("FAIL loop_hold: got %h want 02", ui_drive); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL loop_ovf: got %b want 1", bus.overflow); end
        total++; if (bus.cap_count !== 5'd16) begin bad++; $display("FAIL loop_count: got %0d want 16", bus.cap_count); end
        bus.cap_rd_addr = 4'd4;
        #1;
        total++; if (bus.cap_rd_data !== 16'h0F33) begin bad++; $display("FAIL loop_cap4: got %h want 0F33", bus.cap_rd_data); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL loop_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_start_stop_and_write_drop();
        bus.mode = 2'd0; bus.stim_len = 5'd4;
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ss_busy: got %b want 0", bus.busy); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ss_ovf_kept: got %b want 1", bus.overflow); end
        total++; if (ui_drive !== 8'h02) begin bad++; $display("FAIL ss_hold: got %h want 02", ui_drive); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 16'h00FF;
        tick();
        bus.wr_en = 1'b0;
        total++; if (ui_drive !== 8'h01) begin bad++; $display("FAIL drop_e1: got %h want 01", ui_drive); end
        tick();
        total++; if (ui_drive !== 8'h02) begin bad++; $display("FAIL drop_e2: got %h want 02", ui_drive); end
        total++; if (uio_drive !== 8'h00) begin bad++; $display("FAIL drop_uio: got %h want 00", uio_drive); end
        tick();
        tick();
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL drop_done: got %b want 1", bus.done); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bus.mode = 2'd0; bus.stim_len = 5'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        total++; if (ui_drive !== 8'h02) begin bad++; $display("FAIL mid_pre: got %h want 02", ui_drive); end
        rst = 1'b1;
        #2;
        total++; if (ui_drive !== 8'h00) begin bad++; $display("FAIL mid_ui: got %h want 00", ui_drive); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        total++; if (bus.cap_count !== 5'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", bus.cap_count); end
        #3;
        rst = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_idle: got %b want 0", bus.busy); end
        test_single("rerun");
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'd0; bus.stim_len = 5'd4;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.cap_rd_addr = '0;
        trig_mask = '0; trig_value = '0; dut_uio = 8'hFF; dut_uio_oe = 8'h0F;
        loop_en = 1'b0; uo_force = 8'h00;
        tick();
        tick();
        test_reset();
        #3;
        rst = 1'b0;
        tick();
        write_stim(4'd0, 16'h0001);
        write_stim(4'd1, 16'h0002);
        write_stim(4'd2, 16'h0004);
        write_stim(4'd3, 16'h0008);
        test_single("single");
        test_loopback_capture();
        test_trigger();
        test_loop();
        test_start_stop_and_write_drop();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
